// File: rtl/jacobian_inverse_sequencer_pkg.sv
// Shared types and constants for the 2x2 Jacobian inverse sequencer.
package jacobian_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MUL_AD,
        S_MUL_BC,
        S_SUB,
        S_DIV,
        S_MUL_A,
        S_MUL_B,
        S_MUL_C,
        S_MUL_D,
        S_DONE
    } jinv_state_t;

    localparam int DBL_W    = 64;
    localparam int SIGN_BIT = 63;
    localparam int EXP_MSB  = 62;
    localparam int EXP_LSB  = 52;

    localparam logic [DBL_W-1:0] DBL_ONE = 64'h3FF0_0000_0000_0000;

    // Unit slots: index into the per-unit issuer arrays in the top level.
    localparam int N_UNITS = 3;
    localparam int U_MUL   = 0;
    localparam int U_ADD   = 1;
    localparam int U_DIV   = 2;

    // IEEE-754 negation is a pure sign flip; no arithmetic unit needed.
    function automatic logic [DBL_W-1:0] dbl_neg(input logic [DBL_W-1:0] x);
        return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/jacobian_inverse_sequencer_issuer.sv
// Issues one operation to a shared floating-point unit: start pulse,
// held operands, qualified done and a watchdog counter.
module fp_op_issuer
    import jacobian_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             go,
    input  logic [DBL_W-1:0] op_a,
    input  logic [DBL_W-1:0] op_b,
    output logic             start,
    output logic [DBL_W-1:0] unit_a,
    output logic [DBL_W-1:0] unit_b,
    input  logic             done,
    input  logic [DBL_W-1:0] result,
    output logic             fin,
    output logic [DBL_W-1:0] res,
    output logic             tmo
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic             r_start;
    logic             r_wait;
    logic [CW-1:0]    r_cnt;
    logic [DBL_W-1:0] r_a;
    logic [DBL_W-1:0] r_b;

    logic             w_done_ok;
    logic             w_expired;

    // A done in the start cycle, or while nothing is outstanding, is not ours.
    assign w_done_ok = r_wait && !r_start && done;
    // Counter equals the number of cycles since start; done on the same cycle wins.
    assign w_expired = r_wait && (r_cnt == CW'(TIMEOUT));

    assign fin    = w_done_ok;
    assign tmo    = w_expired && !w_done_ok;
    assign res    = result;
    assign start  = r_start;
    assign unit_a = r_a;
    assign unit_b = r_b;

    // Launch, hold operands, and track the outstanding request until done or timeout.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_start <= 1'b0;
            r_wait  <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_start <= go;
            if (go) begin
                r_wait <= 1'b1;
                r_cnt  <= '0;
                r_a    <= op_a;
                r_b    <= op_b;
            end else if (r_wait) begin
                if (w_done_ok || w_expired) begin
                    r_wait <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/jacobian_inverse_sequencer.sv
// 2x2 Jacobian inverse [d -b; -c a]/(ad-bc) computed by time-sharing one
// double multiplier, adder and divider. Each operation is launched on the
// cycle its predecessor's result arrives, so no cycles are lost between ops.
module jacobian_inverse_sequencer
    import jacobian_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DBL_W-1:0] a,
    input  logic [DBL_W-1:0] b,
    input  logic [DBL_W-1:0] c,
    input  logic [DBL_W-1:0] d,
    output logic             busy,
    output logic             data_ready,
    output logic             singular,
    output logic             timeout_err,
    output logic [DBL_W-1:0] ai,
    output logic [DBL_W-1:0] bi_n,
    output logic [DBL_W-1:0] ci_n,
    output logic [DBL_W-1:0] di,
    output logic             mul_start,
    output logic [DBL_W-1:0] mul_a,
    output logic [DBL_W-1:0] mul_b,
    input  logic             mul_done,
    input  logic [DBL_W-1:0] mul_result,
    output logic             add_start,
    output logic [DBL_W-1:0] add_a,
    output logic [DBL_W-1:0] add_b,
    input  logic             add_done,
    input  logic [DBL_W-1:0] add_result,
    output logic             div_start,
    output logic [DBL_W-1:0] div_a,
    output logic [DBL_W-1:0] div_b,
    input  logic             div_done,
    input  logic [DBL_W-1:0] div_result
);

    jinv_state_t      r_state;
    logic             r_busy;
    logic             r_data_ready;
    logic             r_singular;
    logic             r_timeout;
    logic [DBL_W-1:0] r_a, r_b, r_c, r_d;
    logic [DBL_W-1:0] r_ad;
    logic [DBL_W-1:0] r_recip;
    logic [DBL_W-1:0] r_ai, r_bi_n, r_ci_n, r_di;

    logic [N_UNITS-1:0] w_go;
    logic [N_UNITS-1:0] w_start;
    logic [N_UNITS-1:0] w_done;
    logic [N_UNITS-1:0] w_fin;
    logic [N_UNITS-1:0] w_tmo;
    logic [DBL_W-1:0]   w_op_a   [N_UNITS];
    logic [DBL_W-1:0]   w_op_b   [N_UNITS];
    logic [DBL_W-1:0]   w_unit_a [N_UNITS];
    logic [DBL_W-1:0]   w_unit_b [N_UNITS];
    logic [DBL_W-1:0]   w_result [N_UNITS];
    logic [DBL_W-1:0]   w_res    [N_UNITS];

    logic w_op_fin;
    logic w_op_tmo;
    logic w_det_zero;

    // One issuer per shared unit; all share the same watchdog limit.
    for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
        fp_op_issuer #(
            .TIMEOUT (TIMEOUT)
        ) u_issuer (
            .clk    (clk),
            .srst   (reset),
            .go     (w_go[gi]),
            .op_a   (w_op_a[gi]),
            .op_b   (w_op_b[gi]),
            .start  (w_start[gi]),
            .unit_a (w_unit_a[gi]),
            .unit_b (w_unit_b[gi]),
            .done   (w_done[gi]),
            .result (w_result[gi]),
            .fin    (w_fin[gi]),
            .res    (w_res[gi]),
            .tmo    (w_tmo[gi])
        );
    end

    assign w_done[U_MUL]   = mul_done;
    assign w_done[U_ADD]   = add_done;
    assign w_done[U_DIV]   = div_done;
    assign w_result[U_MUL] = mul_result;
    assign w_result[U_ADD] = add_result;
    assign w_result[U_DIV] = div_result;

    assign mul_start = w_start[U_MUL];
    assign mul_a     = w_unit_a[U_MUL];
    assign mul_b     = w_unit_b[U_MUL];
    assign add_start = w_start[U_ADD];
    assign add_a     = w_unit_a[U_ADD];
    assign add_b     = w_unit_b[U_ADD];
    assign div_start = w_start[U_DIV];
    assign div_a     = w_unit_a[U_DIV];
    assign div_b     = w_unit_b[U_DIV];

    assign busy        = r_busy;
    assign data_ready  = r_data_ready;
    assign singular    = r_singular;
    assign timeout_err = r_timeout;
    assign ai          = r_ai;
    assign bi_n        = r_bi_n;
    assign ci_n        = r_ci_n;
    assign di          = r_di;

    // Zero or subnormal determinant: exponent field all zeros.
    assign w_det_zero = (w_res[U_ADD][EXP_MSB:EXP_LSB] == '0);

    // Select the unit being waited on and launch the next op on its completion.
    always_comb begin
        w_go     = '0;
        w_op_fin = 1'b0;
        w_op_tmo = 1'b0;
        for (int u = 0; u < N_UNITS; u++) begin
            w_op_a[u] = '0;
            w_op_b[u] = '0;
        end

        case (r_state)
            S_MUL_AD, S_MUL_BC, S_MUL_A, S_MUL_B, S_MUL_C, S_MUL_D: begin
                w_op_fin = w_fin[U_MUL];
                w_op_tmo = w_tmo[U_MUL];
            end
            S_SUB: begin
                w_op_fin = w_fin[U_ADD];
                w_op_tmo = w_tmo[U_ADD];
            end
            S_DIV: begin
                w_op_fin = w_fin[U_DIV];
                w_op_tmo = w_tmo[U_DIV];
            end
            default: ;
        endcase

        case (r_state)
            S_IDLE: if (enable) begin
                w_go[U_MUL]   = 1'b1;
                w_op_a[U_MUL] = a;
                w_op_b[U_MUL] = d;
            end
            S_MUL_AD: if (w_op_fin) begin
                w_go[U_MUL]   = 1'b1;
                w_op_a[U_MUL] = r_b;
                w_op_b[U_MUL] = r_c;
            end
            S_MUL_BC: if (w_op_fin) begin
                w_go[U_ADD]   = 1'b1;
                w_op_a[U_ADD] = r_ad;
                w_op_b[U_ADD] = dbl_neg(w_res[U_MUL]);
            end
            S_SUB: if (w_op_fin && !w_det_zero) begin
                w_go[U_DIV]   = 1'b1;
                w_op_a[U_DIV] = DBL_ONE;
                w_op_b[U_DIV] = w_res[U_ADD];
            end
            S_DIV: if (w_op_fin) begin
                w_go[U_MUL]   = 1'b1;
                w_op_a[U_MUL] = r_a;
                w_op_b[U_MUL] = w_res[U_DIV];
            end
            S_MUL_A: if (w_op_fin) begin
                w_go[U_MUL]   = 1'b1;
                w_op_a[U_MUL] = dbl_neg(r_b);
                w_op_b[U_MUL] = r_recip;
            end
            S_MUL_B: if (w_op_fin) begin
                w_go[U_MUL]   = 1'b1;
                w_op_a[U_MUL] = dbl_neg(r_c);
                w_op_b[U_MUL] = r_recip;
            end
            S_MUL_C: if (w_op_fin) begin
                w_go[U_MUL]   = 1'b1;
                w_op_a[U_MUL] = r_d;
                w_op_b[U_MUL] = r_recip;
            end
            default: ;
        endcase
    end

    // Sequencer FSM: accept, capture each op result on its done cycle, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b0;
            r_singular   <= 1'b0;
            r_timeout    <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_ad         <= '0;
            r_recip      <= '0;
            r_ai         <= '0;
            r_bi_n       <= '0;
            r_ci_n       <= '0;
            r_di         <= '0;
        end else begin
            r_data_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_c        <= c;
                        r_d        <= d;
                        r_busy     <= 1'b1;
                        r_singular <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_ai       <= '0;
                        r_bi_n     <= '0;
                        r_ci_n     <= '0;
                        r_di       <= '0;
                        r_state    <= S_MUL_AD;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    if (w_op_tmo) begin
                        // Partial products already written must not be reported.
                        r_timeout    <= 1'b1;
                        r_ai         <= '0;
                        r_bi_n       <= '0;
                        r_ci_n       <= '0;
                        r_di         <= '0;
                        r_data_ready <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (w_op_fin) begin
                        case (r_state)
                            S_MUL_AD: begin
                                r_ad    <= w_res[U_MUL];
                                r_state <= S_MUL_BC;
                            end
                            S_MUL_BC: r_state <= S_SUB;
                            S_SUB: begin
                                if (w_det_zero) begin
                                    r_singular   <= 1'b1;
                                    r_data_ready <= 1'b1;
                                    r_state      <= S_DONE;
                                end else begin
                                    r_state <= S_DIV;
                                end
                            end
                            S_DIV: begin
                                r_recip <= w_res[U_DIV];
                                r_state <= S_MUL_A;
                            end
                            // a*r is the lower-right element of the inverse.
                            S_MUL_A: begin
                                r_di    <= w_res[U_MUL];
                                r_state <= S_MUL_B;
                            end
                            S_MUL_B: begin
                                r_bi_n  <= w_res[U_MUL];
                                r_state <= S_MUL_C;
                            end
                            S_MUL_C: begin
                                r_ci_n  <= w_res[U_MUL];
                                r_state <= S_MUL_D;
                            end
                            // d*r is the upper-left element of the inverse.
                            S_MUL_D: begin
                                r_ai         <= w_res[U_MUL];
                                r_data_ready <= 1'b1;
                                r_state      <= S_DONE;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
